// File: rtl/shot_renderer.sv
// rtl/shot_renderer.sv - serial pixel renderer for up to NUM_SHOTS vertical bullet sprites.
// Optional y clipping against SCREEN_H is compiled in with SHOT_RENDER_CLIP_EN.
module shot_renderer #(
  parameter int         NUM_SHOTS   = 4,
  parameter int         SHOT_LEN    = 2,
  parameter int         COORD_W     = 8,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] SHOT_COLOUR = 3'b010
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_SHOTS*COORD_W-1:0]   shot_x,
  input  logic [NUM_SHOTS*COORD_W-1:0]   shot_y,
  input  logic [NUM_SHOTS-1:0]           shot_valid,
  output logic [COORD_W-1:0]             x,
  output logic [COORD_W-1:0]             y,
  output logic [2:0]                     colour,
  output logic                           plot,
  output logic                           busy,
  output logic                           done
);

  localparam int IDX_W = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
  localparam int K_W   = (SHOT_LEN > 1) ? $clog2(SHOT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SHOTS - 1);
  localparam logic [K_W-1:0]   LAST_K   = K_W'(SHOT_LEN - 1);

  if (NUM_SHOTS < 1 || NUM_SHOTS > 16 || SHOT_LEN < 1 || SHOT_LEN > 8 || SCREEN_H < 1) begin : g_bad_cfg
    $error("shot_renderer: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAW,
    FINISH
  } state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [K_W-1:0]               k_q, k_d;
  logic [NUM_SHOTS*COORD_W-1:0] snap_x_q, snap_x_d;
  logic [NUM_SHOTS*COORD_W-1:0] snap_y_q, snap_y_d;
  logic [NUM_SHOTS-1:0]         snap_valid_q, snap_valid_d;
  logic [COORD_W-1:0]           x_q, x_d;
  logic [COORD_W-1:0]           y_q, y_d;
  logic [2:0]                   colour_q, colour_d;
  logic                         plot_q, plot_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic               cur_valid;
  logic [COORD_W-1:0] pix_y;
  logic               pix_ok;

  assign cur_x     = snap_x_q[int'(idx_q)*COORD_W +: COORD_W];
  assign cur_y     = snap_y_q[int'(idx_q)*COORD_W +: COORD_W];
  assign cur_valid = snap_valid_q[idx_q];

`ifdef SHOT_RENDER_CLIP_EN
  localparam logic [COORD_W:0] SCREEN_H_W = (COORD_W + 1)'(SCREEN_H);
  logic [COORD_W:0] y_sum_w;

  // Carry bit kept so rows that run past the coordinate range are dropped, not wrapped.
  assign y_sum_w = {1'b0, cur_y} + (COORD_W + 1)'(k_q);
  assign pix_y   = y_sum_w[COORD_W-1:0];
  assign pix_ok  = !y_sum_w[COORD_W] && (y_sum_w < SCREEN_H_W);
`else
  assign pix_y  = cur_y + COORD_W'(k_q);
  assign pix_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    k_d          = k_q;
    snap_x_d     = snap_x_q;
    snap_y_d     = snap_y_q;
    snap_valid_d = snap_valid_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = 3'b000;
    plot_d       = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          snap_x_d     = shot_x;
          snap_y_d     = shot_y;
          snap_valid_d = shot_valid;
          idx_d        = '0;
          k_d          = '0;
          busy_d       = 1'b1;
          state_d      = SCAN;
        end
      end

      SCAN: begin
        if (cur_valid) begin
          k_d     = '0;
          state_d = DRAW;
        end else if (idx_q == LAST_IDX) begin
          state_d = FINISH;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DRAW: begin
        // A clipped row still takes its cycle so frame timing never depends on position.
        if (pix_ok) begin
          x_d      = cur_x;
          y_d      = pix_y;
          colour_d = SHOT_COLOUR;
          plot_d   = 1'b1;
        end
        if (k_q == LAST_K) begin
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      k_q          <= '0;
      snap_x_q     <= '0;
      snap_y_q     <= '0;
      snap_valid_q <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= 3'b000;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      k_q          <= k_d;
      snap_x_q     <= snap_x_d;
      snap_y_q     <= snap_y_d;
      snap_valid_q <= snap_valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_shot_renderer.sv
// tb/tb_shot_renderer.sv - table-driven, scoreboarded bench for shot_renderer.
// Expected pixels follow the SHOT_RENDER_CLIP_EN setting of the build.
module tb_shot_renderer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] shot_x;
  logic [31:0] shot_y;
  logic [3:0]  shot_valid;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    string       name;
    logic [3:0]  valid;
    logic [31:0] xs;
    logic [31:0] ys;
    int          done_cyc;
  } vec_t;

  vec_t vecs[6];

  shot_renderer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .shot_x     (shot_x),
    .shot_y     (shot_y),
    .shot_valid (shot_valid),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
  endtask

  // Scoreboard model: push every pixel the frame should plot, in emission order.
  task automatic push_expected(input logic [3:0] valid, input logic [31:0] xs, input logic [31:0] ys);
    logic [8:0] sum;
    for (int i = 0; i < 4; i++) begin
      if (valid[i]) begin
        for (int k = 0; k < 2; k++) begin
          sum = {1'b0, ys[i*8 +: 8]} + 9'(k);
`ifdef SHOT_RENDER_CLIP_EN
          if (sum[8] || sum >= 9'd120) continue;
`endif
          exp_q.push_back({xs[i*8 +: 8], sum[7:0]});
        end
      end
    end
  endtask

  // Called #1 after a posedge; start is seen at the next edge (cycle 0).
  task automatic run_frame(input string nm, input logic [3:0] valid, input logic [31:0] xs,
                           input logic [31:0] ys, input int done_cyc,
                           input int restart_cyc, input logic [31:0] restart_ys);
    logic [15:0] e;
    logic [15:0] last;
    bit          have_last;
    bit          got_done;
    int          c;
    have_last = 0;
    got_done  = 0;
    exp_q.delete();
    push_expected(valid, xs, ys);
    shot_valid = valid;
    shot_x     = xs;
    shot_y     = ys;
    start      = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    c = 0;
    chk({nm, "_busy_after_start"}, busy, 1);
    chk({nm, "_no_done_at_start"}, done, 0);
    while (!got_done && c < 40) begin
      @(posedge clock);
      #1;
      c++;
      if (c == restart_cyc) begin
        start  = 1'b1;
        shot_y = restart_ys;
      end else begin
        start = 1'b0;
      end
      if (plot) begin
        if (exp_q.size() == 0) begin
          chk({nm, "_unexpected_plot"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({nm, "_pix_x"}, x, e[15:8]);
          chk({nm, "_pix_y"}, y, e[7:0]);
          chk({nm, "_pix_colour"}, colour, 3'b010);
          last      = e;
          have_last = 1;
        end
      end else begin
        chk({nm, "_idle_colour"}, colour, 0);
      end
      if (done) begin
        got_done = 1;
        chk({nm, "_done_cycle"}, c, done_cyc);
        chk({nm, "_busy_in_done"}, busy, 0);
      end else if (!got_done) begin
        chk({nm, "_busy_while_running"}, busy, 1);
      end
    end
    if (!got_done) chk({nm, "_done_timeout"}, c, done_cyc);
    chk({nm, "_pixels_left"}, exp_q.size(), 0);
    if (have_last) begin
      chk({nm, "_hold_x"}, x, last[15:8]);
      chk({nm, "_hold_y"}, y, last[7:0]);
    end
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clock);
      #1;
      chk({nm, "_post_done"}, done, 0);
      chk({nm, "_post_plot"}, plot, 0);
      chk({nm, "_post_busy"}, busy, 0);
    end
  endtask

  initial begin
    vecs[0] = '{"single", 4'b0001, {8'd0, 8'd0, 8'd0, 8'd10}, {8'd0, 8'd0, 8'd0, 8'd20}, 7};
    vecs[1] = '{"sparse", 4'b1010, {8'd100, 8'd77, 8'd5, 8'd33}, {8'd50, 8'd66, 8'd5, 8'd44}, 9};
    vecs[2] = '{"none", 4'b0000, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 5};
    vecs[3] = '{"all", 4'b1111, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd9, 8'd8, 8'd7, 8'd6}, 13};
    vecs[4] = '{"wrap", 4'b0001, {8'd0, 8'd0, 8'd0, 8'd30}, {8'd0, 8'd0, 8'd0, 8'd255}, 7};
    vecs[5] = '{"edge119", 4'b1000, {8'd200, 8'd0, 8'd0, 8'd0}, {8'd119, 8'd0, 8'd0, 8'd0}, 7};

    reset      = 1'b1;
    start      = 1'b0;
    shot_x     = '0;
    shot_y     = '0;
    shot_valid = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_x", x, 0);
    chk("reset_y", y, 0);
    chk("reset_colour", colour, 0);
    chk("reset_plot", plot, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].name, vecs[i].valid, vecs[i].xs, vecs[i].ys, vecs[i].done_cyc, -1, '0);

    // Second start mid-DRAW with shot 0 moved to y=40: frame still uses the snapshot.
    run_frame("restart", 4'b0001, {8'd0, 8'd0, 8'd0, 8'd10}, {8'd0, 8'd0, 8'd0, 8'd20}, 7,
              2, {8'd0, 8'd0, 8'd0, 8'd40});

    // Asynchronous reset while the first pixel is on the outputs.
    shot_valid = 4'b0001;
    shot_x     = {8'd0, 8'd0, 8'd0, 8'd10};
    shot_y     = {8'd0, 8'd0, 8'd0, 8'd20};
    start      = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("mid_draw_plot", plot, 1);
    chk("mid_draw_y", y, 20);
    reset = 1'b1;
    #1;
    chk("async_reset_x", x, 0);
    chk("async_reset_y", y, 0);
    chk("async_reset_plot", plot, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    run_frame("after_reset", vecs[0].valid, vecs[0].xs, vecs[0].ys, vecs[0].done_cyc, -1, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
